spi_reg_responder: RTL
======================

// Module: spi_reg_responder
// PURPOSE
//  SPI mode-0 responder exposing an 8-bit register file to an external SPI initiator (spi_master).
//  Oversamples sclk/mosi/cs on the system clock; decodes a command byte, then writes or reads data bytes.
//  Sits between the SPI pins and on-chip logic; registers are also readable locally and writes are strobed out.
// PARAMETERS
//  ADDR_W   3   register address width; register count NREGS = 2**ADDR_W (addr = cmd[ADDR_W-1:0])
//  SYNC_FF  2   synchronizer depth on spi_clk, mosi and cs (>=2)
// PORTS
//  clk        in   1       system clock; must be >= 8x spi_clk frequency
//  reset      in   1       synchronous, active-high
//  spi_clk    in   1       SPI clock from initiator, idle low (CPOL=0, CPHA=0)
//  cs         in   1       chip select, active-low
//  mosi       in   1       initiator-to-responder data, MSB first
//  miso       out  1       responder-to-initiator data, MSB first
//  wr_valid   out  1       1-clk pulse: register wr_addr written with wr_data
//  wr_addr    out  ADDR_W  address of last SPI write
//  wr_data    out  8       data of last SPI write
//  usr_raddr  in   ADDR_W  local read address
//  usr_rdata  out  8       regfile[usr_raddr], combinational
//  frame_err  out  1       1-clk pulse: cs released with a partial byte
// BEHAVIOUR
//  - Reset: all regs=0x00, state IDLE, miso=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, bit count 0.
//  - Inputs pass SYNC_FF flops; edges detected on synced spi_clk. Sample mosi on rise, shift miso on fall.
//  - Frame = cs low. Byte 0 = command: bit7 1=write/0=read, bits[ADDR_W-1:0]=addr, other bits ignored.
//  - FSM: IDLE -(cs falls)-> CMD -(8th rise)-> DATA; DATA -(8 more rises)-> DATA (next byte);
//    any state -(cs high)-> IDLE. Bit counter 0..7, reset on cs fall and each byte completion.
//  - Write: on 8th rise of data byte, regfile[addr]<=byte; wr_valid pulses next clk with wr_addr/wr_data.
//  - Read: regfile[addr] latched on 8th rise of command; its MSB driven on miso at the 8th fall
//    (before first data-byte rise); remaining bits on following falls. Data latched at that point.
//  - miso = 0 during CMD, in IDLE and after a read byte ends if no further byte is served.
//  - cs high mid-byte: partial byte discarded, no write, frame_err pulses once, -> IDLE.
//  - cs high on byte boundary: clean end, no frame_err. Edges on spi_clk while cs high ignored.
//  - Local write and SPI write never conflict: SPI is the only writer. usr_rdata reflects write next clk.
//  - Reset mid-frame: immediate IDLE; responder waits for a new cs falling edge before decoding.
// CONFIGURATION
//  SPI_REG_AUTOINC_EN defined: after each data byte, addr <= addr+1 (wraps NREGS-1 -> 0);
//    further bytes in same frame write/read consecutive registers (burst). Read preloads next reg at byte end.
//  Not defined: only first data byte acted on; later bytes in frame ignored (no write, miso=0).
// STRUCTURE
//  - Shared header spi_defs.vh: SPI_CMD_WR_BIT=7, state encodings ST_IDLE/ST_CMD/ST_DATA, BYTE_BITS=8.
//  - Sub-module spi_edge_sync: SYNC_FF-deep synchronizer + rise/fall pulse outputs; one instance per
//    input (rise/fall used only for spi_clk, cs fall/rise for frame start/end).
//  - Top: FSM, bit counter, rx/tx shift regs, regfile array.
// TESTING
//  1 Write: cs low, send 0x83,0xB5, cs high -> wr_valid once, wr_addr=3, wr_data=0xB5; usr_raddr=3 -> 0xB5.
//  2 Read: after test 1, send 0x03,0x00 -> initiator receives 0x00 then 0xB5; no wr_valid.
//  3 Abort: send 0x85 then 4 bits, cs high -> frame_err pulse, regfile[5] unchanged, next frame works.
//  4 Burst (with SPI_REG_AUTOINC_EN): 0x86,0x11,0x22,0x33 -> regs 6=0x11, 7=0x22, 0=0x33 (wrap).
//    Without macro: only reg6=0x11, one wr_valid.
//  5 Reset: assert reset mid data byte -> all outputs/regs to reset values; following 0x81,0xA5 writes reg1.
//  6 Idle noise: toggle spi_clk/mosi with cs high -> no wr_valid, no frame_err, miso stays 0.

Source files
------------

// File: rtl/spi_reg_responder_pkg.sv
// Shared definitions for the SPI register responder.
//   BYTE_BITS      : bits per SPI byte
//   SPI_CMD_WR_BIT : command-byte bit selecting write (1) or read (0)
//   spi_state_e    : responder frame FSM encoding
package spi_reg_responder_pkg;

  localparam int BYTE_BITS      = 8;
  localparam int SPI_CMD_WR_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_reg_responder_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer for one asynchronous input with
// single-cycle rise/fall pulses derived from the synchronized level.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high; chain clears to 0
//   din   in  asynchronous input
//   dout  out synchronized level
//   rise  out 1-clk pulse on synchronized 0->1
//   fall  out 1-clk pulse on synchronized 1->0
// The chain clears to 0 so that a frame already in progress when reset
// drops (cs held low) does not produce a spurious falling edge.
module spi_edge_sync #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_FF-1:0] sync_q;
  logic               prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], din};
      prev_q <= sync_q[SYNC_FF-1];
    end
  end

  assign dout = sync_q[SYNC_FF-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 responder exposing an 8-bit register file.
// Byte 0 of a frame is a command (bit7 = write, low ADDR_W bits = address);
// following bytes are written to or read from the addressed register.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   spi_clk, cs, mosi   SPI pins from the initiator (oversampled)
//   miso                SPI data to the initiator, MSB first
//   wr_valid/addr/data  1-clk strobe describing each SPI register write
//   usr_raddr/usr_rdata local combinational read port
//   frame_err           1-clk pulse when cs rises with a partial byte
// Build option: define SPI_REG_AUTOINC_EN to enable burst access with the
// address incrementing (and wrapping) after every data byte. Without it
// only the first data byte of a frame is acted on.
module spi_reg_responder
  import spi_reg_responder_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] usr_raddr,
  output logic [7:0]        usr_rdata,
  output logic              frame_err
);

  localparam int         NREGS    = 2 ** ADDR_W;
  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.SYNC_FF(SYNC_FF)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(spi_clk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.SYNC_FF(SYNC_FF)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(.SYNC_FF(SYNC_FF)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e           state, state_nxt;
  logic [2:0]           bit_cnt;
  logic [BYTE_BITS-1:0] rx_sh, tx_sh, rx_next;
  logic [ADDR_W-1:0]    addr;
  logic                 is_wr;
  logic                 data_en;
  logic                 byte_done;
  logic [BYTE_BITS-1:0] regs [NREGS];

`ifdef SPI_REG_AUTOINC_EN
  logic [ADDR_W-1:0] addr_inc;
  assign addr_inc = addr + 1'b1;
`endif

  // The sclk level is only needed for its edges.
  logic sclk_level_unused;
  assign sclk_level_unused = sclk_s;

  assign rx_next   = {rx_sh[BYTE_BITS-2:0], mosi_s};
  assign byte_done = (bit_cnt == LAST_BIT);
  assign usr_rdata = regs[usr_raddr];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
        ST_CMD:  if (sclk_rise && byte_done) state_nxt = ST_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      addr      <= '0;
      is_wr     <= 1'b0;
      data_en   <= 1'b0;
      miso      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_valid  <= 1'b0;
      // cs rising while a byte is half-shifted: the FSM is still out of
      // IDLE in this cycle, so the partial byte is visible in bit_cnt.
      frame_err <= cs_rise && (state != ST_IDLE) && (bit_cnt != 3'd0);

      if (cs_s || state == ST_IDLE) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
        data_en <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_sh   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (state == ST_CMD) begin
              is_wr   <= rx_next[SPI_CMD_WR_BIT];
              addr    <= rx_next[ADDR_W-1:0];
              tx_sh   <= regs[rx_next[ADDR_W-1:0]];
              data_en <= 1'b1;
            end else if (data_en) begin
              if (is_wr) begin
                regs[addr] <= rx_next;
                wr_valid   <= 1'b1;
                wr_addr    <= addr;
                wr_data    <= rx_next;
              end
`ifdef SPI_REG_AUTOINC_EN
              addr  <= addr_inc;
              tx_sh <= regs[addr_inc];
`else
              data_en <= 1'b0;
`endif
            end
          end
        end

        // Falling edges shift read data out; the fall ending the command
        // byte presents the MSB before the first data-byte rise.
        if (sclk_fall) begin
          if (state == ST_DATA && data_en && !is_wr) begin
            miso  <= tx_sh[BYTE_BITS-1];
            tx_sh <= {tx_sh[BYTE_BITS-2:0], 1'b0};
          end else begin
            miso <= 1'b0;
          end
        end
      end
    end
  end

endmodule
